// File: rtl/seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_display : multiplexed multi-digit 7-segment driver, board clock |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module seg_scan_display #(
   parameter int DIGITS         = 8,
   parameter int DIV            = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [4*DIGITS-1:0]         data_in,
   input  logic                        load,
   input  logic                        enable,
   input  logic                        blank_lz,
   output logic [6:0]                  seg,
   output logic [DIGITS-1:0]           sel,
   output logic [$clog2(DIGITS)-1:0]   digit_idx
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam int CNT_W = $clog2(DIV);

   localparam logic [6:0]        c_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] c_SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                   : {DIGITS{1'b0}};

   logic [4*DIGITS-1:0] r_shadow;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_sel;

   logic [3:0]          w_nib;
   logic                w_zero_digit;
   logic [6:0]          w_pat;
   logic [6:0]          w_seg_lit;
   logic [DIGITS-1:0]   w_onehot;
   logic [DIGITS-1:0]   w_sel_lit;
   logic                w_cnt_last;
   logic                w_idx_last;
   logic [DIGITS:1]     w_zero_from;

   // w_zero_from[i] is set when nibble i and every nibble above it are zero
   assign w_zero_from[DIGITS] = 1'b1;
   for (genvar g = 1; g < DIGITS; g++) begin : g_lz
      assign w_zero_from[g] = w_zero_from[g+1] & (r_shadow[4*g +: 4] == 4'h0);
   end

   // Digit 0 is never a leading zero, so it is the default selection
   always_comb begin
      w_nib        = r_shadow[3:0];
      w_zero_digit = 1'b0;
      for (int i = 1; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib        = r_shadow[4*i +: 4];
            w_zero_digit = w_zero_from[i];
         end
      end
   end

   always_comb begin
      w_pat = 7'h00;
      case (w_nib)
         4'h0:    w_pat = 7'h3F;
         4'h1:    w_pat = 7'h06;
         4'h2:    w_pat = 7'h5B;
         4'h3:    w_pat = 7'h4F;
         4'h4:    w_pat = 7'h66;
         4'h5:    w_pat = 7'h6D;
         4'h6:    w_pat = 7'h7D;
         4'h7:    w_pat = 7'h07;
         4'h8:    w_pat = 7'h7F;
         4'h9:    w_pat = 7'h6F;
         4'hA:    w_pat = 7'h77;
         4'hB:    w_pat = 7'h7C;
         4'hC:    w_pat = 7'h39;
         4'hD:    w_pat = 7'h5E;
         4'hE:    w_pat = 7'h79;
         default: w_pat = 7'h71;
      endcase
   end

   assign w_seg_lit  = (blank_lz && w_zero_digit) ? c_SEG_OFF
                     : ((SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat);
   assign w_onehot   = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
   assign w_sel_lit  = (SEL_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
   assign w_cnt_last = (r_cnt == CNT_W'(DIV - 1));
   assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadow <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_seg    <= c_SEG_OFF;
         r_sel    <= c_SEL_OFF;
      end else begin
         if (load) begin
            r_shadow <= data_in;
         end
         if (enable) begin
            r_seg <= w_seg_lit;
            // Select stays dark for the first cycle of each slot to avoid ghosting
            r_sel <= (r_cnt == '0) ? c_SEL_OFF : w_sel_lit;
            if (w_cnt_last) begin
               r_cnt <= '0;
               r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_seg <= c_SEG_OFF;
            r_sel <= c_SEL_OFF;
         end
      end
   end

   assign seg       = r_seg;
   assign sel       = r_sel;
   assign digit_idx = r_idx;

endmodule
`default_nettype wire
